// File: rtl/vx_commit_collector.sv
// vx_commit_collector: round-robin commit arbiter with atomic multi-packet lock, 2-entry writeback FIFO and retire counter.
// Define VX_COMMIT_COLLECTOR_PERF_EN to add per-source eop commit counters on perf_src_commits.
module vx_commit_collector #(
    parameter int NUM_SOURCES = 4,
    parameter int NUM_LANES   = 4,
    parameter int NUM_WARPS   = 4,
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int RD_W        = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SOURCES-1:0]            in_valid,
    output logic [NUM_SOURCES-1:0]            in_ready,
    input  logic [NUM_SOURCES*WID_W-1:0]      in_wid,
    input  logic [NUM_SOURCES*XLEN-1:0]       in_pc,
    input  logic [NUM_SOURCES*RD_W-1:0]       in_rd,
    input  logic [NUM_SOURCES-1:0]            in_wb,
    input  logic [NUM_SOURCES*NUM_LANES-1:0]  in_tmask,
    input  logic [NUM_SOURCES*NUM_LANES*XLEN-1:0] in_data,
    input  logic [NUM_SOURCES-1:0]            in_sop,
    input  logic [NUM_SOURCES-1:0]            in_eop,
    output logic                              wb_valid,
    input  logic                              wb_ready,
    output logic [WID_W-1:0]                  wb_wid,
    output logic [XLEN-1:0]                   wb_pc,
    output logic [RD_W-1:0]                   wb_rd,
    output logic                              wb_we,
    output logic [NUM_LANES-1:0]              wb_tmask,
    output logic [NUM_LANES*XLEN-1:0]         wb_data,
    output logic                              wb_eop,
    output logic                              retire_valid,
    output logic [WID_W-1:0]                  retire_wid,
    output logic [63:0]                       commit_total
`ifdef VX_COMMIT_COLLECTOR_PERF_EN
    ,output logic [NUM_SOURCES*32-1:0]        perf_src_commits
`endif
);
    localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int DW = NUM_LANES * XLEN;
    localparam int PW = WID_W + XLEN + RD_W + 1 + NUM_LANES + DW + 1;

    logic [SW-1:0] ptr, lock_src, gnt, idx;
    logic          lock, found, accept, pop, eop;
    logic [1:0]    count;
    logic          wr_ptr, rd_ptr;
    logic [PW-1:0] mem [2];
    logic [PW-1:0] in_pkt;

    // Descending scan so the source closest to the pointer is the last to claim the grant.
    always_comb begin
        gnt = ptr;
        found = 1'b0;
        idx = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            idx = SW'((int'(ptr) + k) % NUM_SOURCES);
            if (in_valid[idx]) begin
                gnt = idx;
                found = 1'b1;
            end
        end
        if (lock) begin
            gnt = lock_src;
            found = 1'b1;
        end
    end

    assign in_ready = (reset && found && count != 2'd2) ? NUM_SOURCES'(1) << gnt : '0;
    assign accept   = |(in_valid & in_ready);
    assign eop      = in_eop[gnt];
    assign wb_valid = count != 2'd0;
    assign pop      = wb_valid && wb_ready;
    assign in_pkt   = {in_wid[gnt*WID_W +: WID_W], in_pc[gnt*XLEN +: XLEN], in_rd[gnt*RD_W +: RD_W],
                       in_wb[gnt], in_tmask[gnt*NUM_LANES +: NUM_LANES], in_data[gnt*DW +: DW], eop};
    assign {wb_wid, wb_pc, wb_rd, wb_we, wb_tmask, wb_data, wb_eop} = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
            ptr <= '0;
            lock <= 1'b0;
            lock_src <= '0;
            retire_valid <= 1'b0;
            retire_wid <= '0;
            commit_total <= '0;
        end else begin
            count <= count + 2'(accept) - 2'(pop);
            if (accept) begin
                mem[wr_ptr] <= in_pkt;
                wr_ptr <= ~wr_ptr;
                lock <= !eop;
                lock_src <= gnt;
                if (eop) ptr <= (gnt == SW'(NUM_SOURCES - 1)) ? '0 : gnt + 1'b1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            retire_valid <= pop && wb_eop;
            if (pop && wb_eop) begin
                retire_wid <= wb_wid;
                commit_total <= commit_total + 64'd1;
            end
        end
    end

`ifdef VX_COMMIT_COLLECTOR_PERF_EN
    logic [31:0] perf_cnt [NUM_SOURCES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SOURCES; k++) perf_cnt[k] <= '0;
        end else if (accept && eop) begin
            perf_cnt[gnt] <= perf_cnt[gnt] + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_perf
        assign perf_src_commits[i*32 +: 32] = perf_cnt[i];
    end
`endif
endmodule

// File: doc/vx_commit_collector.md
Name: vx_commit_collector

Overview:
Receiving end of the per-issue-slot commit interface. Collects commit packets from NUM_SOURCES execute units (ALU, LSU, FPU, SFU) belonging to one issue slot and arbitrates them round-robin. Multi-packet commits stay atomic. The winning packet is buffered in a 2-entry elastic FIFO and presented to register-file writeback. Each instruction that completes its final packet is retired to the scheduler.

Parameters:
NUM_SOURCES, 4, number of execute units feeding this slot
NUM_LANES, 4, lanes per commit packet
NUM_WARPS, 4, warps; WID_W = max(1, clog2(NUM_WARPS))
XLEN, 32, data and PC width
NUM_REGS, 32, architectural registers; RD_W = clog2(NUM_REGS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  NUM_SOURCES  per-source packet valid
in_ready  out  NUM_SOURCES  per-source accept
in_wid  in  NUM_SOURCES*WID_W  warp id
in_pc  in  NUM_SOURCES*XLEN  instruction PC
in_rd  in  NUM_SOURCES*RD_W  destination register
in_wb  in  NUM_SOURCES  register write enable
in_tmask  in  NUM_SOURCES*NUM_LANES  thread mask
in_data  in  NUM_SOURCES*NUM_LANES*XLEN  lane results
in_sop  in  NUM_SOURCES  first packet of instruction
in_eop  in  NUM_SOURCES  last packet of instruction
wb_valid  out  1  writeback packet valid
wb_ready  in  1  writeback accept
wb_wid / wb_pc / wb_rd / wb_we / wb_tmask / wb_data / wb_eop  out  as inputs  buffered packet fields
retire_valid  out  1  one-cycle instruction retire pulse
retire_wid  out  WID_W  warp of retired instruction
commit_total  out  64  count of retired instructions

Behaviour:
- Reset is asynchronous and active-low. It clears the FIFO (count=0), sets the priority pointer to 0, clears the lock, and sets commit_total=0.
- During reset: in_ready=0, wb_valid=0, retire_valid=0, retire_wid=0, and all wb_* fields are 0.
- Arbiter grant selection:
  - If no lock is held, grant the first valid source at or after the pointer, in rotating order.
  - If the lock is held, the grant is fixed to the locked source.
- Locking:
  - The lock is set when a granted source is accepted with eop=0.
  - The lock is cleared when the locked source is accepted with eop=1.
  - A single-packet instruction (sop=eop=1) never locks.
- If the locked source drops in_valid, the grant stays with it. No other source is served until its eop is accepted.
- Pointer update: on an accepted packet with eop=1, the pointer becomes (granted+1) mod NUM_SOURCES. It is unchanged otherwise.
- in_ready[i] = (grant==i) && (count<2), computed combinationally from the registered count. At most one in_ready bit is high.
- The FIFO holds 2 entries. An accepted packet appears on wb_* on the next cycle, so latency is 1 cycle.
  - Simultaneous push and pop keeps count unchanged.
  - At count==2 nothing is accepted.
  - The FIFO preserves order.
- wb_valid = (count!=0). Output fields hold steady while wb_valid && !wb_ready.
- Packets with in_wb=0 still pass through with wb_we=0. They are still retired.
- Retire: on a wb handshake with wb_eop=1, in the next cycle:
  - retire_valid=1 for exactly one cycle;
  - retire_wid = that packet's wid;
  - commit_total increments by 1.
- Back-to-back eop handshakes produce consecutive retire pulses.
- commit_total wraps modulo 2^64.

Optional Feature:
VX_COMMIT_COLLECTOR_PERF_EN
- Defined: adds output perf_src_commits (NUM_SOURCES*32). Each 32-bit slice counts eop packets accepted from that source. Counters reset to 0 and wrap at 2^32.
- Undefined: the port and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset with all 4 sources valid (sop=eop=1), wb_ready=1, then release reset.
   - Sources are accepted in order 0,1,2,3,0.
   - wb_valid rises 1 cycle after each accept.
   - commit_total reaches 5.
2. Source 1 sends 3 packets (sop=1/eop=0, 0/0, 0/1) while source 2 is continuously valid.
   - Source 2 is not granted until source 1's eop is accepted.
   - The source-1 packets emerge contiguously on wb.
   - A single retire_valid pulse fires, with retire_wid = source 1's wid.
3. Hold wb_ready=0 with source 0 streaming.
   - Exactly 2 packets are accepted, then in_ready=0.
   - wb_data stays stable.
   - When wb_ready=1 is restored, the packets drain in order.
4. Packet with in_wb=0, rd=5, tmask=4'b1010.
   - Output shows wb_we=0, wb_rd=5, wb_tmask=4'b1010.
   - The packet is still retired and commit_total increments.
5. Assert reset mid-way through a locked multi-packet sequence with the FIFO full.
   - Same cycle: wb_valid=0 and in_ready=0.
   - After release: the lock is cleared, the pointer is 0, and source 0 wins first.
6. With VX_COMMIT_COLLECTOR_PERF_EN defined, run scenario 1 for 8 rounds.
   - Each perf_src_commits slice equals 8.
